// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - program-buffer driven instruction issuer and result collector
// Streams prog[] into the pipeline with optional bubbles and captures ALUIn LATENCY cycles later.
module instr_issue_unit #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int LATENCY = 2,
  parameter int GAP     = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [31:0]   LoadData,
  input  logic          Start,
  input  logic [AW:0]   NumInstr,
  input  logic [31:0]   ALUIn,
  input  logic [AW-1:0] ResAddr,
  output logic [31:0]   InstrOut,
  output logic          WriteEnable,
  output logic [31:0]   ResData,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [2:0] {IDLE, ISSUE, BUBBLE, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [AW:0]               pc_q, pc_d;
  logic [AW:0]               n_q, n_d;
  logic [2:0]                bub_q, bub_d;
  logic [LATENCY-1:0]        dl_v_q, dl_v_d;
  logic [LATENCY-1:0][AW-1:0] dl_idx_q, dl_idx_d;
  logic [31:0]               instr_q, instr_d;
  logic                      we_q, we_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      push_v;
  logic                      pend;
  logic                      running;

  logic [31:0] prog_mem [DEPTH];
  logic [31:0] res_mem  [DEPTH];

  assign running = (state_q == ISSUE) || (state_q == BUBBLE) || (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    n_d     = n_q;
    bub_d   = bub_q;
    instr_d = 32'h0;
    we_d    = 1'b0;
    push_v  = 1'b0;
    busy_d  = running;
    done_d  = (state_q == DONE);
    pend    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          n_d     = (NumInstr > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : NumInstr;
          pc_d    = '0;
          bub_d   = '0;
          state_d = (n_d == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        instr_d = prog_mem[pc_q[AW-1:0]];
        we_d    = 1'b1;
        push_v  = 1'b1;
        pc_d    = pc_q + 1'b1;
        bub_d   = '0;
        if (GAP > 0)
          state_d = BUBBLE;
        else if (pc_d == n_q)
          state_d = DRAIN;
      end
      BUBBLE: begin
        bub_d = bub_q + 1'b1;
        if (bub_q == 3'(GAP - 1))
          state_d = (pc_q == n_q) ? DRAIN : ISSUE;
      end
      DRAIN: ;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    dl_v_d[0]   = push_v;
    dl_idx_d[0] = pc_q[AW-1:0];
    for (int k = 1; k < LATENCY; k++) begin
      dl_v_d[k]   = dl_v_q[k-1];
      dl_idx_d[k] = dl_idx_q[k-1];
    end

    // Leave for DONE once the last slot has reached the tail: its capture lands on the
    // same edge that raises Done, so Done coincides with the last result being visible.
    for (int k = 0; k < LATENCY - 1; k++)
      pend = pend | dl_v_d[k];
    if (running && (pc_d == n_q) && !pend)
      state_d = DONE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      n_q      <= '0;
      bub_q    <= '0;
      dl_v_q   <= '0;
      dl_idx_q <= '0;
      instr_q  <= 32'h0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      n_q      <= n_d;
      bub_q    <= bub_d;
      dl_v_q   <= dl_v_d;
      dl_idx_q <= dl_idx_d;
      instr_q  <= instr_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Buffers survive reset; only in-flight captures are dropped.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (LoadEn && (state_q == IDLE))
        prog_mem[LoadAddr] <= LoadData;
      if (dl_v_q[LATENCY-1])
        res_mem[dl_idx_q[LATENCY-1]] <= ALUIn;
    end
  end

  assign InstrOut    = instr_q;
  assign WriteEnable = we_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign ResData     = res_mem[ResAddr];

endmodule

// File: tb/tb_instr_issue_unit.sv
// tb/tb_instr_issue_unit.sv - directed self-checking bench for instr_issue_unit
// Two instances (GAP=0 and GAP=2, LATENCY=2) each fed by a one-register pipeline returning word+1.
module tb_instr_issue_unit;

  logic        clk = 1'b0;
  logic        rst, load_en, start0, start2;
  logic [3:0]  load_addr, res_addr;
  logic [31:0] load_data;
  logic [4:0]  num;
  logic [31:0] alu0, alu2;
  logic [31:0] instr0, instr2, res0, res2;
  logic        we0, we2, busy0, busy2, done0, done2;

  int          vectors = 0;
  int          errs = 0;
  logic [31:0] pm  [16];
  logic [31:0] er0 [16];
  logic [34:0] lg  [1:40];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    alu0 <= instr0 + 32'd1;
    alu2 <= instr2 + 32'd1;
  end

  instr_issue_unit #(.DEPTH(16), .AW(4), .LATENCY(2), .GAP(0)) dut0 (
    .Clk(clk), .Reset(rst), .LoadEn(load_en), .LoadAddr(load_addr), .LoadData(load_data),
    .Start(start0), .NumInstr(num), .ALUIn(alu0), .ResAddr(res_addr),
    .InstrOut(instr0), .WriteEnable(we0), .ResData(res0), .Busy(busy0), .Done(done0));

  instr_issue_unit #(.DEPTH(16), .AW(4), .LATENCY(2), .GAP(2)) dut2 (
    .Clk(clk), .Reset(rst), .LoadEn(load_en), .LoadAddr(load_addr), .LoadData(load_data),
    .Start(start2), .NumInstr(num), .ALUIn(alu2), .ResAddr(res_addr),
    .InstrOut(instr2), .WriteEnable(we2), .ResData(res2), .Busy(busy2), .Done(done2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick;
    load_en = 1'b0;
    pm[a] = d;
  endtask

  task automatic log_cycle(input bit sel, input int c);
    lg[c] = sel ? {we2, busy2, done2, instr2} : {we0, busy0, done0, instr0};
  endtask

  task automatic run_log(input bit sel, input logic [4:0] n, input int ncyc);
    num = n;
    if (sel) start2 = 1'b1; else start0 = 1'b1;
    tick;
    start0 = 1'b0; start2 = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      tick;
      log_cycle(sel, c);
    end
  endtask

  // Expected per-cycle {WriteEnable, Busy, Done, InstrOut} from the published timing.
  task automatic verify_run(input string tag, input int g, input int n, input int ncyc);
    int nn, t;
    logic e_we, e_busy, e_done;
    logic [31:0] e_instr;
    nn = (n > 16) ? 16 : n;
    t  = 1 + (nn - 1) * (1 + g);
    for (int c = 1; c <= ncyc; c++) begin
      e_we = 1'b0; e_instr = 32'h0;
      for (int i = 0; i < nn; i++)
        if (c == 1 + i * (1 + g)) begin
          e_we = 1'b1; e_instr = pm[i];
        end
      e_busy = (nn > 0) && (c <= t + 1);
      e_done = (nn == 0) ? (c == 1) : (c == t + 2);
      chk($sformatf("%s_c%0d", tag, c), 64'(lg[c]), 64'({e_we, e_busy, e_done, e_instr}));
    end
  endtask

  task automatic check_res(input bit sel, input string tag, input int i, input logic [31:0] exp);
    res_addr = 4'(i);
    #1;
    chk($sformatf("%s_res%0d", tag, i), 64'(sel ? res2 : res0), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; load_en = 1'b0; start0 = 1'b0; start2 = 1'b0;
    load_addr = '0; load_data = '0; num = '0; res_addr = '0;
    tick; tick;
    chk("reset_dut0", 64'({we0, busy0, done0, instr0}), 64'h0);
    chk("reset_dut2", 64'({we2, busy2, done2, instr2}), 64'h0);
    rst = 1'b0;
    tick;

    load(4'd0, 32'h00a1_0020);
    load(4'd1, 32'h0123_4567);
    load(4'd2, 32'hdead_0000);

    // three back-to-back instructions
    run_log(1'b0, 5'd3, 8);
    verify_run("gap0_n3", 0, 3, 8);
    for (int i = 0; i < 3; i++) check_res(1'b0, "gap0_n3", i, pm[i] + 32'd1);

    // two instructions with two bubbles each
    run_log(1'b1, 5'd2, 8);
    verify_run("gap2_n2", 2, 2, 8);
    for (int i = 0; i < 2; i++) check_res(1'b1, "gap2_n2", i, pm[i] + 32'd1);

    // empty run
    run_log(1'b0, 5'd0, 4);
    verify_run("n0", 0, 0, 4);

    // NumInstr above DEPTH clamps to 16
    for (int i = 0; i < 16; i++) load(4'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101);
    run_log(1'b0, 5'd20, 20);
    verify_run("clamp", 0, 20, 20);
    cnt = 0;
    for (int c = 1; c <= 20; c++) if (lg[c][34]) cnt++;
    chk("clamp_we_count", 64'(cnt), 64'd16);
    for (int i = 0; i < 16; i++) er0[i] = pm[i] + 32'd1;
    check_res(1'b0, "clamp", 0, er0[0]);
    check_res(1'b0, "clamp", 15, er0[15]);

    // reset during cycle 3 of a 4-instruction run: only instruction 0 gets captured
    for (int i = 0; i < 4; i++) load(4'(i), 32'h5a5a_0000 + 32'(i));
    num = 5'd4; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_outputs", 64'({we0, busy0, done0, instr0}), 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk($sformatf("rst_quiet_c%0d", c), 64'({we0, busy0, done0}), 64'h0);
    end
    er0[0] = pm[0] + 32'd1;
    for (int i = 0; i < 4; i++) check_res(1'b0, "rst", i, er0[i]);

    // restart with a same-cycle load of address 0
    pm[0] = 32'hcafe_f00d;
    load_en = 1'b1; load_addr = 4'd0; load_data = 32'hcafe_f00d;
    num = 5'd4; start0 = 1'b1;
    tick;
    load_en = 1'b0; start0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick;
      log_cycle(1'b0, c);
    end
    verify_run("restart", 0, 4, 8);
    for (int i = 0; i < 4; i++) check_res(1'b0, "restart", i, pm[i] + 32'd1);

    // Start and LoadEn while busy are ignored
    num = 5'd2; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    tick;
    log_cycle(1'b0, 1);
    load_en = 1'b1; load_addr = 4'd1; load_data = 32'hbad0_bad0;
    start0 = 1'b1; num = 5'd5;
    tick;
    log_cycle(1'b0, 2);
    load_en = 1'b0; start0 = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      tick;
      log_cycle(1'b0, c);
    end
    verify_run("busy_ign", 0, 2, 10);
    cnt = 0;
    for (int c = 1; c <= 10; c++) if (lg[c][32]) cnt++;
    chk("busy_ign_done_count", 64'(cnt), 64'd1);
    run_log(1'b0, 5'd2, 5);
    verify_run("busy_ign_prog", 0, 2, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
